// File: rtl/outel_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : outel_irq_pkg
// Purpose  : Register offsets, NMI FSM state encoding and priority helper
//            shared by the outel interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package outel_irq_pkg;

    localparam logic [1:0] c_OFF_PEND = 2'd0;
    localparam logic [1:0] c_OFF_MASK = 2'd1;
    localparam logic [1:0] c_OFF_MODE = 2'd2;
    localparam logic [1:0] c_OFF_ID   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } nmi_state_t;

    // Index of the lowest set bit; bit 0 carries the highest priority.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/outel_irq_if.sv
`default_nettype none
// ============================================================================
// Module   : outel_irq_bus_if
// Purpose  : CPU register-bus bundle between the processor and the
//            interrupt controller register window.
// Revision : 1.0 - initial release
// ============================================================================
interface outel_irq_bus_if;
    logic        bus_strobe;
    logic [15:0] address_bus;
    logic        read_not_write;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_out_valid;

    modport master (
        output bus_strobe, address_bus, read_not_write, data_in,
        input  data_out, data_out_valid
    );

    modport slave (
        input  bus_strobe, address_bus, read_not_write, data_in,
        output data_out, data_out_valid
    );
endinterface
`default_nettype wire

// File: rtl/outel_sync2.sv
`default_nettype none
// ============================================================================
// Module   : outel_sync2
// Purpose  : Two-flop synchronizer for asynchronous request lines.
// Revision : 1.0 - initial release
// ============================================================================
module outel_sync2 #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             nrst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/outel_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : outel_irq_ctrl
// Purpose  : 8-source maskable IRQ controller with edge/level modes and a
//            fixed-length NMI pulse generator. Define OUTEL_IRQ_SYNC_EN to
//            put 2-flop synchronizers on irq_src/nmi_src.
// Revision : 1.0 - initial release
// ============================================================================
module outel_irq_ctrl
    import outel_irq_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFE00,
    parameter int          NMI_PULSE = 4
) (
    input  wire logic       clk,
    input  wire logic       nrst,
    outel_irq_bus_if.slave  bus,
    input  wire logic [7:0] irq_src,
    input  wire logic       nmi_src,
    output logic            interrupt_request,
    output logic            non_maskable_interrupt
);
    localparam logic [3:0] c_PULSE_LEN = 4'(NMI_PULSE);

    logic [7:0]  w_irq_in;
    logic        w_nmi_in;

`ifdef OUTEL_IRQ_SYNC_EN
    outel_sync2 #(.WIDTH(9)) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .i_d  ({nmi_src, irq_src}),
        .o_q  ({w_nmi_in, w_irq_in})
    );
`else
    assign w_irq_in = irq_src;
    assign w_nmi_in = nmi_src;
`endif

    logic [7:0]  r_src, r_src_prev, r_pend, r_mask, r_mode;
    logic        r_nmi_s, r_nmi_prev, r_irq_n, r_nmi_n;
    logic [3:0]  r_cnt, w_cnt_next;
    nmi_state_t  r_state, w_state_next;

    logic [15:0] w_off;
    logic        w_hit, w_wr, w_none;
    logic [1:0]  w_sel;
    logic [7:0]  w_clr, w_rise, w_en_pend, w_pend_next, w_id;

    // Offset subtraction keeps the decode correct for unaligned bases.
    assign w_off     = bus.address_bus - BASE_ADDR;
    assign w_hit     = (w_off < 16'd4);
    assign w_sel     = w_off[1:0];
    assign w_wr      = bus.bus_strobe & ~bus.read_not_write & w_hit;
    assign w_clr     = (w_wr && w_sel == c_OFF_PEND) ? bus.data_in : 8'h00;
    assign w_rise    = r_src & ~r_src_prev;
    assign w_en_pend = r_pend & r_mask;
    assign w_none    = ~|w_en_pend;
    assign w_id      = {w_none, 4'b0000, lowest_idx(w_en_pend)};

    // Level bits mirror the source; edge bits let a new edge beat W1C.
    assign w_pend_next = (r_mode & r_src) | (~r_mode & ((r_pend & ~w_clr) | w_rise));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_src      <= 8'h00;
            r_src_prev <= 8'h00;
            r_pend     <= 8'h00;
            r_mask     <= 8'h00;
            r_mode     <= 8'h00;
            r_irq_n    <= 1'b1;
            r_nmi_s    <= 1'b0;
            r_nmi_prev <= 1'b0;
        end else begin
            r_src      <= w_irq_in;
            r_src_prev <= r_src;
            r_pend     <= w_pend_next;
            r_irq_n    <= w_none;
            r_nmi_s    <= w_nmi_in;
            r_nmi_prev <= r_nmi_s;
            if (w_wr && w_sel == c_OFF_MASK) r_mask <= bus.data_in;
            if (w_wr && w_sel == c_OFF_MODE) r_mode <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_nmi_n <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_nmi_n <= (w_state_next != ST_PULSE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_nmi_s && !r_nmi_prev) begin
                    w_state_next = ST_PULSE;
                    w_cnt_next   = c_PULSE_LEN;
                end
            end
            ST_PULSE: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (!r_nmi_s) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_comb begin
        bus.data_out       = 8'h00;
        bus.data_out_valid = bus.read_not_write & w_hit;
        if (bus.data_out_valid) begin
            case (w_sel)
                c_OFF_PEND: bus.data_out = r_pend;
                c_OFF_MASK: bus.data_out = r_mask;
                c_OFF_MODE: bus.data_out = r_mode;
                default:    bus.data_out = w_id;
            endcase
        end
    end

    assign interrupt_request      = r_irq_n;
    assign non_maskable_interrupt = r_nmi_n;
endmodule
`default_nettype wire

// File: doc/outel_irq_ctrl.md
OUTEL_IRQ_CTRL -- requirements
Module: outel_irq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFE00; base of the 4-byte register window.
REQ-002 SHALL have parameter NMI_PULSE, default 4; NMI low-pulse length in clk cycles, legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit; sole clock.
REQ-004 SHALL have port nrst, input, 1 bit; reset, synchronous and active-low.
REQ-005 SHALL have port bus_strobe, input, 1 bit; one-cycle qualifier marking a completed CPU bus cycle.
REQ-006 SHALL have port address_bus, input, 16 bits; CPU address ({addressBusHigh, addressBusLow}).
REQ-007 SHALL have port read_not_write, input, 1 bit; 1 = CPU read.
REQ-008 SHALL have port data_in, input, 8 bits; CPU write data.
REQ-009 SHALL have port data_out, output, 8 bits; register read data.
REQ-010 SHALL have port data_out_valid, output, 1 bit; high when data_out must drive the CPU read mux.
REQ-011 SHALL have port irq_src, input, 8 bits; peripheral requests, active high, bit 0 = highest priority.
REQ-012 SHALL have port nmi_src, input, 1 bit; NMI request, active high.
REQ-013 SHALL have port interrupt_request, output, 1 bit; to the CPU IRQ input, active low.
REQ-014 SHALL have port non_maskable_interrupt, output, 1 bit; to the CPU NMI input, active low.

Function
REQ-015 SHALL decode offsets from BASE_ADDR as follows:
- +0 PEND: read = pending[7:0]; write = write-1-to-clear.
- +1 MASK: read/write; 1 = enabled.
- +2 MODE: read/write; 1 = level, 0 = rising edge.
- +3 ID: read-only; {none, 4'b0, idx[2:0]}, where none = 1 when no enabled bit is pending.
REQ-016 SHALL perform register writes only on a clk edge where bus_strobe=1, read_not_write=0 and the address hits; writes to ID are ignored.
REQ-017 SHALL drive data_out_valid = read_not_write AND address hit (combinational); data_out SHALL be the addressed register when valid, else 8'h00; reads have no side effects.
REQ-018 In edge mode, a pending bit SHALL be set on a 0->1 transition of the sampled source and held until cleared by W1C.
REQ-019 In level mode, a pending bit SHALL equal the sampled source each cycle; W1C SHALL have no effect.
REQ-020 SHALL give set priority when a set and a W1C of the same bit occur in the same cycle.
REQ-021 SHALL drive interrupt_request = NOT OR(pending AND mask), registered, one cycle after pending/mask update.
REQ-022 ID idx SHALL be the lowest-numbered bit of (pending AND mask).
REQ-023 SHALL implement an NMI FSM with states IDLE, PULSE and HOLD:
- IDLE -> PULSE on a sampled nmi_src rising edge; the counter loads NMI_PULSE.
- PULSE holds non_maskable_interrupt=0, decrementing each cycle; at count 1 it goes to HOLD.
- HOLD -> IDLE once sampled nmi_src=0; edges are ignored in PULSE and HOLD.
REQ-024 Without synchronizers, sampling SHALL add 1 register stage: a source rising at edge N is pending at edge N+2, and interrupt_request is low after edge N+3.

Reset
REQ-025 On nrst=0 at a clk edge:
- pending, mask, mode and the sample/edge registers SHALL clear.
- interrupt_request=1 and non_maskable_interrupt=1.
- the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-026 Reset during PULSE SHALL release non_maskable_interrupt (1) at that same edge.
REQ-027 After reset, a source already high SHALL register as a rising edge on the first sampled cycle.

Configuration
REQ-028 Macro OUTEL_IRQ_SYNC_EN defined: irq_src and nmi_src SHALL pass 2-flop synchronizers before sampling, adding exactly 2 cycles to every latency in REQ-024 and REQ-023.
REQ-029 Macro OUTEL_IRQ_SYNC_EN undefined: no synchronizers; sources SHALL be sampled directly, with latencies exactly as in REQ-024.

Structure
REQ-030 Package outel_irq_pkg SHALL hold the register offset localparams (PEND/MASK/MODE/ID) and the NMI state enum.
REQ-031 Sub-module outel_sync2 (parameterized width, 2-flop) SHALL be instantiated only under OUTEL_IRQ_SYNC_EN.

Verification
REQ-032 The bench SHALL cover these scenarios (macro undefined unless stated):
- Write MASK=8'h05; pulse irq_src[2] at edge 10 -> PEND=8'h04 at edge 12, interrupt_request=0 after 13, ID=8'h02.
- irq_src=8'h06 with MASK=8'hFF -> ID=8'h01; W1C 8'h02 -> ID=8'h02; W1C 8'h04 -> ID=8'h80, interrupt_request=1 next cycle.
- MODE bit 3 = level, irq_src[3] held high; W1C 8'h08 -> PEND[3] stays 1; drop source -> PEND[3]=0 two cycles later.
- nmi_src held high 20 cycles with NMI_PULSE=4 -> non_maskable_interrupt low exactly 4 cycles, a single pulse; drop and re-raise -> second pulse.
- Same-cycle edge on bit 0 and W1C 8'h01 -> PEND[0]=1; assert nrst mid-NMI-pulse -> both outputs 1 at that edge, all registers 8'h00.
- With OUTEL_IRQ_SYNC_EN defined, repeat the first scenario -> PEND at edge 14.
